prol16_bus_monitor: RTL and testbench
=====================================

// Module: prol16_bus_monitor
// PURPOSE
//  Passive monitor downstream of the Prol16 CPU memory bus (cpu_if signals).
//  Samples ce/oe/we strobes, address and data every clock. Folds each access into one read/write transaction record.
//  Buffers the records in a FWFT FIFO with a valid/ready handshake towards the scoreboard.
//  Keeps access counters and sticky halt/illegal/bus-error status.
// PARAMETERS
//  DATA_WIDTH  16  width of address and data words (= gDataWidth)
//  FIFO_DEPTH  8   transaction FIFO entries; power of two, >= 2
//  CNT_WIDTH   32  width of rd/wr/drop counters
// PORTS
//  clk             in   1           clock; all state changes on rising edge
//  rst             in   1           reset, synchronous, active-high
//  mem_addr_i      in   DATA_WIDTH  CPU address (cpu mem_addr_o)
//  mem_rdata_i     in   DATA_WIDTH  data returned to CPU (cpu mem_data_i)
//  mem_wdata_i     in   DATA_WIDTH  data written by CPU (cpu mem_data_o)
//  mem_ce_ni       in   1           chip enable, active-low
//  mem_oe_ni       in   1           output enable, active-low
//  mem_we_ni       in   1           write enable, active-low
//  illegal_inst_i  in   1           CPU illegal-instruction flag
//  cpu_halt_i      in   1           CPU halt flag
//  txn_valid_o     out  1           FIFO head holds a record
//  txn_ready_i     in   1           consumer accepts head this cycle
//  txn_we_o        out  1           head record: 1 = write, 0 = read
//  txn_addr_o      out  DATA_WIDTH  head record address
//  txn_data_o      out  DATA_WIDTH  head record data
//  rd_count_o      out  CNT_WIDTH   completed reads (incl. dropped)
//  wr_count_o      out  CNT_WIDTH   completed writes (incl. dropped)
//  drop_count_o    out  CNT_WIDTH   records lost to a full FIFO
//  overflow_o      out  1           sticky: at least one drop
//  halted_o        out  1           sticky: cpu_halt_i seen
//  illegal_o       out  1           sticky: illegal_inst_i seen
//  bus_err_o       out  1           sticky: ce_n=oe_n=we_n=0 seen
// BEHAVIOUR
//  Reset: every output 0, FIFO empty, FSM IDLE. An open access is discarded, not pushed.
//  Bus kind per sample:
//   - READ  = ce_n=0, oe_n=0, we_n=1
//   - WRITE = ce_n=0, we_n=0, oe_n=1
//   - all else IDLE. ce_n=oe_n=we_n=0 is IDLE and sets bus_err_o.
//  FSM states IDLE/READ/WRITE. State = kind of the last sample; open record = addr, data, we.
//  IDLE->READ|WRITE: open a record with mem_addr_i. WRITE data = mem_wdata_i at entry.
//  READ stays READ with unchanged addr: record data <= mem_rdata_i every cycle, so the last active sample wins.
//  Termination: a sample whose kind differs from the state, or same kind with a changed addr.
//   - The edge that samples it pushes the open record and updates rd/wr_count.
//   - If that sample is itself an access, it opens a new record on the same edge (back-to-back).
//  Latency: txn_valid_o is high in the cycle after the first non-matching sample edge.
//  FIFO is FWFT: txn_* are stable while txn_valid_o=1 and txn_ready_i=0. Pop when valid&ready.
//  Full FIFO with a push and no pop: the record is dropped; drop_count_o+1 and overflow_o<=1. rd/wr_count still count it.
//  Full FIFO with a simultaneous push and pop: both happen, no drop.
//  Empty FIFO with txn_ready_i=1: no effect.
//  Counters saturate at all-ones; no wrap.
//  cpu_halt_i=1 sampled:
//   - halted_o<=1, and an open record is pushed on that edge.
//   - Afterwards the FSM stays IDLE and bus activity is ignored until rst. The FIFO still drains.
//  illegal_inst_i=1 sampled: illegal_o<=1. Capture continues.
//  rst has priority over push, pop and halt on the same edge.
// TESTING
//  - Read A=0x0010, rdata 0x1111 then 0x2222 over 2 active cycles, then IDLE -> one record {we=0,0x0010,0x2222}; valid the cycle after the IDLE edge; rd_count=1.
//  - WRITE 0x0020/0xBEEF directly followed by READ 0x0021/0x0042, then IDLE -> records {1,0x0020,0xBEEF} then {0,0x0021,0x0042}, in order; wr=rd=1.
//  - txn_ready_i=0, 9 single-cycle reads, DEPTH=8 -> 8 records kept, drop_count=1, overflow_o=1, rd_count=9. A push and pop on the same edge while full -> no drop.
//  - All strobes low for 1 cycle mid-write -> bus_err_o=1, the write is pushed, the next cycle counts as IDLE.
//  - cpu_halt_i during an open read -> record pushed, halted_o=1, later strobes give no records. The FIFO still drains. illegal_inst_i pulse -> illegal_o stays 1.
//  - rst asserted with 3 records queued and a read open -> next cycle all outputs 0. A read active at rst release opens a new record.

Source files
------------

// File: rtl/prol16_bus_monitor.sv
// rtl/prol16_bus_monitor.sv - passive Prol16 memory-bus monitor with transaction FIFO and status counters
module prol16_bus_monitor #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  input  logic                  mem_ce_ni,
  input  logic                  mem_oe_ni,
  input  logic                  mem_we_ni,
  input  logic                  illegal_inst_i,
  input  logic                  cpu_halt_i,
  output logic                  txn_valid_o,
  input  logic                  txn_ready_i,
  output logic                  txn_we_o,
  output logic [DATA_WIDTH-1:0] txn_addr_o,
  output logic [DATA_WIDTH-1:0] txn_data_o,
  output logic [CNT_WIDTH-1:0]  rd_count_o,
  output logic [CNT_WIDTH-1:0]  wr_count_o,
  output logic [CNT_WIDTH-1:0]  drop_count_o,
  output logic                  overflow_o,
  output logic                  halted_o,
  output logic                  illegal_o,
  output logic                  bus_err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = 2 * DATA_WIDTH + 1;
  localparam logic [AW:0]          DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [AW-1:0]        PTR_ONE = AW'(1);
  localparam logic [AW:0]          OCC_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_t;

  state_t                r_state;
  state_t                w_kind;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_halted;
  logic                  r_illegal;
  logic                  r_bus_err;
  logic                  r_overflow;
  logic [CNT_WIDTH-1:0]  r_rd_count;
  logic [CNT_WIDTH-1:0]  r_wr_count;
  logic [CNT_WIDTH-1:0]  r_drop_count;

  logic [RW-1:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_occ;

  logic                  w_capture;
  logic                  w_is_read;
  logic                  w_is_write;
  logic                  w_bus_err;
  logic                  w_term;
  logic                  w_open;
  logic                  w_valid;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [RW-1:0]         w_head;

  // Once halted (or on the halting edge) the bus is treated as idle so nothing new opens.
  assign w_capture  = !r_halted && !cpu_halt_i;
  assign w_is_read  = !mem_ce_ni && !mem_oe_ni &&  mem_we_ni;
  assign w_is_write = !mem_ce_ni &&  mem_oe_ni && !mem_we_ni;
  assign w_bus_err  = !mem_ce_ni && !mem_oe_ni && !mem_we_ni;

  // Classify the current bus sample; contention and everything unrecognised fold into IDLE.
  always_comb begin
    w_kind = ST_IDLE;
    if (w_capture && w_is_read) begin
      w_kind = ST_READ;
    end else if (w_capture && w_is_write) begin
      w_kind = ST_WRITE;
    end
  end

  // The open record closes when the access kind changes or the address moves within the same kind.
  assign w_term = (r_state != ST_IDLE) && ((w_kind != r_state) || (mem_addr_i != r_addr));
  assign w_open = (w_kind != ST_IDLE) && ((r_state == ST_IDLE) || w_term);

  assign w_valid = (r_occ != '0);
  assign w_full  = (r_occ == DEPTH_L);
  assign w_pop   = w_valid && txn_ready_i;
  // A full FIFO still accepts a record when the head leaves on the same edge.
  assign w_push  = w_term && (!w_full || w_pop);
  assign w_drop  = w_term && w_full && !w_pop;
  assign w_head  = r_mem[r_rd_ptr];

  // Capture FSM, access counters and sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_data       <= '0;
      r_halted     <= 1'b0;
      r_illegal    <= 1'b0;
      r_bus_err    <= 1'b0;
      r_overflow   <= 1'b0;
      r_rd_count   <= '0;
      r_wr_count   <= '0;
      r_drop_count <= '0;
    end else begin
      r_state <= w_kind;
      if (cpu_halt_i) begin
        r_halted <= 1'b1;
      end
      if (illegal_inst_i) begin
        r_illegal <= 1'b1;
      end
      if (w_capture && w_bus_err) begin
        r_bus_err <= 1'b1;
      end
      if (w_open) begin
        r_addr <= mem_addr_i;
        r_data <= (w_kind == ST_WRITE) ? mem_wdata_i : mem_rdata_i;
      end else if (r_state == ST_READ && w_kind == ST_READ) begin
        r_data <= mem_rdata_i;
      end
      if (w_term && r_state == ST_WRITE && r_wr_count != CNT_MAX) begin
        r_wr_count <= r_wr_count + CNT_ONE;
      end
      if (w_term && r_state == ST_READ && r_rd_count != CNT_MAX) begin
        r_rd_count <= r_rd_count + CNT_ONE;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != CNT_MAX) begin
          r_drop_count <= r_drop_count + CNT_ONE;
        end
      end
    end
  end

  // FWFT FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + OCC_ONE;
      end else if (!w_push && w_pop) begin
        r_occ <= r_occ - OCC_ONE;
      end
    end
  end

  // FIFO storage; contents are don't-care while the entry is unoccupied.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= {(r_state == ST_WRITE), r_addr, r_data};
    end
  end

  assign txn_valid_o  = w_valid;
  assign txn_we_o     = w_valid & w_head[RW-1];
  assign txn_addr_o   = w_valid ? w_head[RW-2:DATA_WIDTH] : '0;
  assign txn_data_o   = w_valid ? w_head[DATA_WIDTH-1:0] : '0;
  assign rd_count_o   = r_rd_count;
  assign wr_count_o   = r_wr_count;
  assign drop_count_o = r_drop_count;
  assign overflow_o   = r_overflow;
  assign halted_o     = r_halted;
  assign illegal_o    = r_illegal;
  assign bus_err_o    = r_bus_err;

endmodule

// File: tb/tb_prol16_bus_monitor.sv
// tb/tb_prol16_bus_monitor.sv - self-checking bench for prol16_bus_monitor
module tb_prol16_bus_monitor;

  localparam int K_IDLE = 0;
  localparam int K_RD   = 1;
  localparam int K_WR   = 2;
  localparam int K_ERR  = 3;
  localparam int K_ID2  = 4;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } rec_t;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [15:0] rdata;
    logic [15:0] wdata;
    logic        push;
    logic        ewe;
    logic [15:0] eaddr;
    logic [15:0] edata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr, mem_rdata, mem_wdata;
  logic        ce_n, oe_n, we_n;
  logic        illegal, halt, ready;
  logic        txn_valid, txn_we;
  logic [15:0] txn_addr, txn_data;
  logic [31:0] rd_count, wr_count, drop_count;
  logic        overflow, halted, illegal_s, bus_err;

  rec_t sb_q[$];
  vec_t vecs[14];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  prol16_bus_monitor #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .mem_addr_i(mem_addr), .mem_rdata_i(mem_rdata), .mem_wdata_i(mem_wdata),
    .mem_ce_ni(ce_n), .mem_oe_ni(oe_n), .mem_we_ni(we_n),
    .illegal_inst_i(illegal), .cpu_halt_i(halt),
    .txn_valid_o(txn_valid), .txn_ready_i(ready),
    .txn_we_o(txn_we), .txn_addr_o(txn_addr), .txn_data_o(txn_data),
    .rd_count_o(rd_count), .wr_count_o(wr_count), .drop_count_o(drop_count),
    .overflow_o(overflow), .halted_o(halted), .illegal_o(illegal_s), .bus_err_o(bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_rec(input logic we, input logic [15:0] addr, input logic [15:0] data);
    rec_t r;
    r.we = we;
    r.addr = addr;
    r.data = data;
    sb_q.push_back(r);
  endtask

  // Drive one bus sample, compare any record handed over this cycle, advance one clock.
  task automatic step(input int kind, input logic [15:0] addr, input logic [15:0] rdata,
                      input logic [15:0] wdata);
    rec_t e;
    case (kind)
      K_RD:    {ce_n, oe_n, we_n} = 3'b001;
      K_WR:    {ce_n, oe_n, we_n} = 3'b010;
      K_ERR:   {ce_n, oe_n, we_n} = 3'b000;
      K_ID2:   {ce_n, oe_n, we_n} = 3'b100;
      default: {ce_n, oe_n, we_n} = 3'b111;
    endcase
    mem_addr = addr;
    mem_rdata = rdata;
    mem_wdata = wdata;
    @(negedge clk);
    if (txn_valid && ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got record we=%0b addr=0x%04h data=0x%04h expected none",
                 txn_we, txn_addr, txn_data);
      end else begin
        e = sb_q.pop_front();
        chk("sb_we", 32'(txn_we), 32'(e.we));
        chk("sb_addr", 32'(txn_addr), 32'(e.addr));
        chk("sb_data", 32'(txn_data), 32'(e.data));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(K_IDLE, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    ready = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    illegal = 1'b0;
    halt = 1'b0;
    ready = 1'b0;
    mem_addr = '0; mem_rdata = '0; mem_wdata = '0;
    {ce_n, oe_n, we_n} = 3'b111;

    vecs[0]  = '{K_RD,   16'h0010, 16'h1111, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{K_RD,   16'h0010, 16'h2222, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[2]  = '{K_IDLE, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h2222};
    vecs[3]  = '{K_WR,   16'h0020, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[4]  = '{K_RD,   16'h0021, 16'h0042, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'hBEEF};
    vecs[5]  = '{K_IDLE, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0021, 16'h0042};
    vecs[6]  = '{K_WR,   16'h0040, 16'h0000, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[7]  = '{K_WR,   16'h0040, 16'h0000, 16'h5678, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[8]  = '{K_RD,   16'h0050, 16'h0A0A, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h1234};
    vecs[9]  = '{K_RD,   16'h0051, 16'h0B0B, 16'h0000, 1'b1, 1'b0, 16'h0050, 16'h0A0A};
    vecs[10] = '{K_WR,   16'h0051, 16'h0000, 16'h7777, 1'b1, 1'b0, 16'h0051, 16'h0B0B};
    vecs[11] = '{K_WR,   16'h0052, 16'h0000, 16'h8888, 1'b1, 1'b1, 16'h0051, 16'h7777};
    vecs[12] = '{K_ID2,  16'h0052, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0052, 16'h8888};
    vecs[13] = '{K_IDLE, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};

    // Reset state
    idle(2);
    chk("rst_valid", 32'(txn_valid), 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_flags", {28'd0, overflow, halted, illegal_s, bus_err}, 0);
    rst = 1'b0;
    sb_q.delete();

    // Table-driven captures with the consumer always ready
    ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].push) expect_rec(vecs[i].ewe, vecs[i].eaddr, vecs[i].edata);
      step(vecs[i].kind, vecs[i].addr, vecs[i].rdata, vecs[i].wdata);
      if (i == 1) chk("lat_before_idle", 32'(txn_valid), 0);
      if (i == 2) begin
        chk("lat_after_idle", 32'(txn_valid), 1);
        chk("rd_count_first", rd_count, 1);
      end
    end
    idle(3);
    chk("tbl_rd_count", rd_count, 4);
    chk("tbl_wr_count", wr_count, 4);
    chk("tbl_drained", 32'(txn_valid), 0);

    // Overflow: 9 reads into an 8-deep FIFO, then push+pop while full
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i >= 1) expect_rec(1'b0, 16'h0100 + 16'(i - 1), 16'hA000 + 16'(i - 1));
      step(K_RD, 16'h0100 + 16'(i), 16'hA000 + 16'(i), 16'h0);
    end
    step(K_IDLE, 16'h0, 16'h0, 16'h0);
    chk("ovf_drop_count", drop_count, 1);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_rd_count", rd_count, 9);
    chk("ovf_valid", 32'(txn_valid), 1);
    step(K_RD, 16'h0200, 16'hC0C0, 16'h0);
    ready = 1'b1;
    expect_rec(1'b0, 16'h0200, 16'hC0C0);
    step(K_IDLE, 16'h0, 16'h0, 16'h0);
    chk("full_pushpop_drop", drop_count, 1);
    idle(10);
    chk("full_pushpop_rd", rd_count, 10);
    chk("ovf_drained", 32'(txn_valid), 0);

    // Bus contention mid-write closes the write; the next sample starts fresh
    expect_rec(1'b1, 16'h0060, 16'hCAFE);
    step(K_WR, 16'h0060, 16'h0, 16'hCAFE);
    step(K_ERR, 16'h0060, 16'h0, 16'hCAFE);
    chk("bus_err", 32'(bus_err), 1);
    expect_rec(1'b1, 16'h0060, 16'hD00D);
    step(K_WR, 16'h0060, 16'h0, 16'hD00D);
    idle(3);
    chk("err_wr_count", wr_count, 2);

    // Illegal pulse, then halt during an open read
    illegal = 1'b1;
    step(K_RD, 16'h0070, 16'h5555, 16'h0);
    illegal = 1'b0;
    step(K_RD, 16'h0070, 16'h5555, 16'h0);
    ready = 1'b0;
    halt = 1'b1;
    expect_rec(1'b0, 16'h0070, 16'h5555);
    step(K_IDLE, 16'h0, 16'h0, 16'h0);
    halt = 1'b0;
    step(K_RD, 16'h0071, 16'h6666, 16'h0);
    step(K_WR, 16'h0072, 16'h0, 16'h7777);
    step(K_IDLE, 16'h0, 16'h0, 16'h0);
    chk("halted", 32'(halted), 1);
    chk("illegal_sticky", 32'(illegal_s), 1);
    chk("halt_rd_count", rd_count, 11);
    chk("halt_wr_count", wr_count, 2);
    chk("halt_valid", 32'(txn_valid), 1);
    ready = 1'b1;
    idle(3);
    chk("halt_drained", 32'(txn_valid), 0);

    // Reset with records queued and a read open
    do_reset();
    illegal = 1'b1;
    step(K_RD, 16'h0080, 16'h8000, 16'h0);
    illegal = 1'b0;
    for (int i = 1; i < 4; i++) step(K_RD, 16'h0080 + 16'(i), 16'h8000 + 16'(i), 16'h0);
    chk("pre_rst_valid", 32'(txn_valid), 1);
    chk("pre_rst_rd", rd_count, 3);
    rst = 1'b1;
    step(K_RD, 16'h0090, 16'h9090, 16'h0);
    chk("mid_rst_valid", 32'(txn_valid), 0);
    chk("mid_rst_txn", {15'd0, txn_we, txn_addr}, 0);
    chk("mid_rst_data", 32'(txn_data), 0);
    chk("mid_rst_counts", rd_count | wr_count | drop_count, 0);
    chk("mid_rst_flags", {28'd0, overflow, halted, illegal_s, bus_err}, 0);
    rst = 1'b0;
    sb_q.delete();
    ready = 1'b1;
    expect_rec(1'b0, 16'h0090, 16'h9191);
    step(K_RD, 16'h0090, 16'h9191, 16'h0);
    idle(3);
    chk("post_rst_rd", rd_count, 1);

    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
